// File: rtl/arc4_encrypt.sv
// arc4_encrypt: RC4 encryption engine.
// Reads a length-prefixed plaintext from pt memory, runs KSA and PRGA over
// the external S memory and writes a length-prefixed ciphertext to ct memory.
// All memories have a registered address: read data is valid in the cycle
// after the address is presented; writes commit on the edge where wren=1.
// Handshake: en is accepted only while rdy=1 (IDLE); the key is latched on that
// edge, rdy drops the following cycle and returns one cycle after the last
// ciphertext write. en while rdy=0 is ignored.
// Optional macro ARC4_ENCRYPT_CYCLE_COUNT_EN adds a 16-bit saturating 'cycles'
// output counting busy cycles of the most recent run.
module arc4_encrypt #(
    parameter int KEY_BYTES = 3,
    parameter int MEM_AW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [MEM_AW-1:0]      s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic [MEM_AW-1:0]      pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [MEM_AW-1:0]      ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
`ifdef ARC4_ENCRYPT_CYCLE_COUNT_EN
    ,
    output logic [15:0]            cycles
`endif
);

    typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA} state_t;

    state_t                 state, state_n;
    logic [2:0]             step, step_n;
    logic [7:0]             i, i_n, j, j_n, k, k_n;
    logic [7:0]             si, si_n, sj, sj_n, len, len_n, ptb, ptb_n;
    logic [8*KEY_BYTES-1:0] key_r, key_n;
    logic [7:0]             s_a, pt_a, ct_a;
    logic [7:0]             i_inc;

    assign i_inc   = i + 8'd1;
    assign s_addr  = MEM_AW'(s_a);
    assign pt_addr = MEM_AW'(pt_a);
    assign ct_addr = MEM_AW'(ct_a);

    // State and datapath registers; reset returns everything to idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            len   <= '0;
            ptb   <= '0;
            key_r <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            i     <= i_n;
            j     <= j_n;
            k     <= k_n;
            si    <= si_n;
            sj    <= sj_n;
            len   <= len_n;
            ptb   <= ptb_n;
            key_r <= key_n;
        end
    end

    // Next-state and memory-port decode; each phase of an iteration is one step.
    always_comb begin
        state_n   = state;
        step_n    = step;
        i_n       = i;
        j_n       = j;
        k_n       = k;
        si_n      = si;
        sj_n      = sj;
        len_n     = len;
        ptb_n     = ptb;
        key_n     = key_r;
        rdy       = (state == IDLE);
        s_a       = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_a      = '0;
        ct_a      = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    key_n   = key;
                    state_n = INIT;
                    step_n  = '0;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                end
            end
            INIT: begin
                s_a      = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                i_n      = i_inc;
                if (i == 8'hFF) state_n = KSA;
            end
            KSA: begin
                // Current key byte is always the top byte; key rotates per i.
                case (step)
                    3'd0: begin s_a = i; step_n = 3'd1; end
                    3'd1: begin
                        si_n   = s_rddata;
                        j_n    = j + s_rddata + key_r[8*KEY_BYTES-1 -: 8];
                        step_n = 3'd2;
                    end
                    3'd2: begin s_a = j; step_n = 3'd3; end
                    3'd3: begin
                        s_a = i; s_wrdata = s_rddata; s_wren = 1'b1;
                        step_n = 3'd4;
                    end
                    default: begin
                        // i==j writes the same value twice, so the swap stays correct.
                        s_a = j; s_wrdata = si; s_wren = 1'b1;
                        key_n  = (key_r << 8) | (key_r >> (8*(KEY_BYTES-1)));
                        i_n    = i_inc;
                        step_n = 3'd0;
                        if (i == 8'hFF) state_n = LEN;
                    end
                endcase
            end
            LEN: begin
                if (step == 3'd0) begin
                    step_n = 3'd1;
                end else begin
                    ct_wren   = 1'b1;
                    ct_wrdata = pt_rddata;
                    len_n     = pt_rddata;
                    i_n       = '0;
                    j_n       = '0;
                    k_n       = 8'd1;
                    step_n    = 3'd0;
                    state_n   = (pt_rddata == 8'd0) ? IDLE : PRGA;
                end
            end
            PRGA: begin
                case (step)
                    3'd0: begin
                        s_a = i_inc; i_n = i_inc; pt_a = k;
                        step_n = 3'd1;
                    end
                    3'd1: begin
                        si_n   = s_rddata;
                        j_n    = j + s_rddata;
                        ptb_n  = pt_rddata;
                        step_n = 3'd2;
                    end
                    3'd2: begin s_a = j; step_n = 3'd3; end
                    3'd3: begin
                        sj_n = s_rddata;
                        s_a = i; s_wrdata = s_rddata; s_wren = 1'b1;
                        step_n = 3'd4;
                    end
                    3'd4: begin
                        s_a = j; s_wrdata = si; s_wren = 1'b1;
                        step_n = 3'd5;
                    end
                    3'd5: begin s_a = si + sj; step_n = 3'd6; end
                    default: begin
                        // k is compared before incrementing, so L=255 ends at k=255.
                        ct_a = k; ct_wrdata = ptb ^ s_rddata; ct_wren = 1'b1;
                        k_n    = k + 8'd1;
                        step_n = 3'd0;
                        if (k == len) state_n = IDLE;
                    end
                endcase
            end
            default: begin
                state_n = IDLE;
                step_n  = '0;
            end
        endcase
    end

`ifdef ARC4_ENCRYPT_CYCLE_COUNT_EN
    // Busy-cycle counter: cleared on accept, saturating, held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else if (state == IDLE) begin
            if (en) cycles <= '0;
        end else if (cycles != 16'hFFFF) begin
            cycles <= cycles + 16'd1;
        end
    end
`endif

endmodule
